// File: rtl/crc32_stream.sv
// Streaming reflected CRC-32 engine with valid/ready input, latched FCS,
// residue check and optional LSB-first FCS emission.
module crc32_stream #(
    parameter int unsigned DATA_W    = 2,
    parameter logic [31:0] INIT      = 32'hFFFF_FFFF,
    parameter logic [31:0] POLY_REFL = 32'hEDB8_8320,
    parameter logic [31:0] RESIDUE   = 32'hDEBB_20E3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              append_en,
    output logic [31:0]       fcs_out,
    output logic              crc_done,
    output logic              fcs_good,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int unsigned N  = 32 / DATA_W;
    localparam int unsigned KW = $clog2(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic {
        RUN,
        EMIT
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [KW-1:0] k;
    logic [KW-1:0] k_nx;
    logic [31:0]   crc;
    logic [31:0]   crc_upd;
    logic          accept;

    function automatic logic [31:0] crc_next(
        input logic [31:0]       c,
        input logic [DATA_W-1:0] d
    );
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < DATA_W; i++) begin
            fb = r[0] ^ d[i];
            r  = (r >> 1) ^ (fb ? POLY_REFL : 32'h0);
        end
        return r;
    endfunction

    assign crc_upd = crc_next(crc, in_data);
    // start outranks data, so a beat coinciding with it is dropped
    assign accept  = in_valid && (state == RUN) && !start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            k     <= '0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        k_nx      = k;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        unique case (state)
            RUN: begin
                in_ready = 1'b1;
                if (accept && in_last && append_en) begin
                    state_nx = EMIT;
                    k_nx     = '0;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_data  = fcs_out[32'(k) * DATA_W +: DATA_W];
                out_last  = (k == K_LAST);
                if (out_ready) begin
                    if (k == K_LAST) begin
                        state_nx = RUN;
                        k_nx     = '0;
                    end else begin
                        k_nx = k + KW'(1);
                    end
                end
            end
        endcase
        if (start) begin
            state_nx = RUN;
            k_nx     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc      <= INIT;
            fcs_out  <= '0;
            fcs_good <= 1'b0;
            crc_done <= 1'b0;
        end else begin
            crc_done <= 1'b0;
            if (start) begin
                crc <= INIT;
            end else if (accept) begin
                if (in_last) begin
                    crc      <= INIT;
                    fcs_out  <= ~crc_upd;
                    fcs_good <= (crc_upd == RESIDUE);
                    crc_done <= 1'b1;
                end else begin
                    crc <= crc_upd;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc32_stream.sv
// Bench for crc32_stream: three widths (8, 2, 4) against a byte-level
// CRC-32 model and a per-cycle scoreboard of done pulses and FCS beats.
module tb_crc32_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_s[3];
    logic        in_valid_s[3];
    logic        in_last_s[3];
    logic        app_s[3];
    logic        ordy_s[3];
    logic        ir_s[3];
    logic [31:0] fcs_s[3];
    logic        done_s[3];
    logic        good_s[3];
    logic        ov_s[3];
    logic        ol_s[3];
    logic [7:0]  id0;
    logic [1:0]  id1;
    logic [3:0]  id2;
    logic [7:0]  od0;
    logic [1:0]  od1;
    logic [3:0]  od2;

    crc32_stream #(.DATA_W(8)) u8 (
        .clk(clk), .rst(rst), .start(start_s[0]),
        .in_valid(in_valid_s[0]), .in_ready(ir_s[0]),
        .in_data(id0), .in_last(in_last_s[0]),
        .append_en(app_s[0]), .fcs_out(fcs_s[0]),
        .crc_done(done_s[0]), .fcs_good(good_s[0]),
        .out_valid(ov_s[0]), .out_ready(ordy_s[0]),
        .out_data(od0), .out_last(ol_s[0])
    );

    crc32_stream #(.DATA_W(2)) u2 (
        .clk(clk), .rst(rst), .start(start_s[1]),
        .in_valid(in_valid_s[1]), .in_ready(ir_s[1]),
        .in_data(id1), .in_last(in_last_s[1]),
        .append_en(app_s[1]), .fcs_out(fcs_s[1]),
        .crc_done(done_s[1]), .fcs_good(good_s[1]),
        .out_valid(ov_s[1]), .out_ready(ordy_s[1]),
        .out_data(od1), .out_last(ol_s[1])
    );

    crc32_stream #(.DATA_W(4)) u4 (
        .clk(clk), .rst(rst), .start(start_s[2]),
        .in_valid(in_valid_s[2]), .in_ready(ir_s[2]),
        .in_data(id2), .in_last(in_last_s[2]),
        .append_en(app_s[2]), .fcs_out(fcs_s[2]),
        .crc_done(done_s[2]), .fcs_good(good_s[2]),
        .out_valid(ov_s[2]), .out_ready(ordy_s[2]),
        .out_data(od2), .out_last(ol_s[2])
    );

    typedef struct {
        int          inst;
        int          cyc;
        logic [31:0] fcs;
        logic        good;
    } done_ev_t;

    typedef struct {
        int         inst;
        logic [7:0] d;
        logic       last;
    } beat_ev_t;

    done_ev_t    dq[$];
    beat_ev_t    eq[$];
    int          em_start[3];
    logic [31:0] m_fcs[3];
    logic        m_good[3];
    int          done_cnt[3];
    logic [7:0]  seen[$];
    int          cyc = 0;
    bit          armed = 0;
    int          total = 0;
    int          passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    function automatic int wid(input int id);
        case (id)
            0: return 8;
            1: return 2;
            default: return 4;
        endcase
    endfunction

    // Plain byte-wise reflected CRC-32, no final inversion
    function automatic logic [31:0] model_reg(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c ^= {24'h0, b[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [7:0] get_beat(input logic [7:0] b[$],
                                            input int n, input int w);
        logic [7:0] r;
        int         j;
        r = '0;
        for (int t = 0; t < w; t++) begin
            j    = n * w + t;
            r[t] = b[j / 8][j % 8];
        end
        return r;
    endfunction

    function automatic logic [7:0] get_od(input int id);
        case (id)
            0: return od0;
            1: return {6'h0, od1};
            default: return {4'h0, od2};
        endcase
    endfunction

    task automatic set_in(input int id, input logic v, input logic [7:0] d,
                          input logic l, input logic a);
        in_valid_s[id] = v;
        in_last_s[id]  = l;
        app_s[id]      = a;
        case (id)
            0: id0 = d;
            1: id1 = d[1:0];
            default: id2 = d[3:0];
        endcase
    endtask

    task automatic model_reset();
        dq.delete();
        eq.delete();
        for (int i = 0; i < 3; i++) begin
            m_fcs[i]  = '0;
            m_good[i] = 1'b0;
        end
    endtask

    task automatic purge_em(input int id);
        eq = eq.find with (item.inst != id);
    endtask

    task automatic check_inst(input int id, input logic done,
                              input logic [31:0] fcs, input logic good,
                              input logic ov, input logic [7:0] od,
                              input logic ol, input logic ir,
                              input logic ordy);
        int   di;
        int   ei;
        logic ev;
        di = -1;
        ei = -1;
        foreach (dq[i]) if (dq[i].inst == id && dq[i].cyc == cyc) di = i;
        chk($sformatf("u%0d_crc_done", id), done, di >= 0);
        if (done) done_cnt[id]++;
        if (di >= 0) begin
            m_fcs[id]  = dq[di].fcs;
            m_good[id] = dq[di].good;
            dq.delete(di);
        end
        chk($sformatf("u%0d_fcs_out", id), fcs, m_fcs[id]);
        chk($sformatf("u%0d_fcs_good", id), good, m_good[id]);
        foreach (eq[i]) if (eq[i].inst == id && ei < 0) ei = i;
        ev = (ei >= 0) && (cyc >= em_start[id]);
        chk($sformatf("u%0d_out_valid", id), ov, ev);
        chk($sformatf("u%0d_in_ready", id), ir, !ev);
        if (ev) begin
            chk($sformatf("u%0d_out_last", id), ol, eq[ei].last);
            chk($sformatf("u%0d_out_data", id), od, eq[ei].d);
            if (ordy) eq.delete(ei);
        end else begin
            chk($sformatf("u%0d_out_last", id), ol, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 3; i++)
                check_inst(i, done_s[i], fcs_s[i], good_s[i], ov_s[i],
                           get_od(i), ol_s[i], ir_s[i], ordy_s[i]);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at 1ns after an edge; returns 1ns after the edge
    // that takes the final beat.
    task automatic send_frame(input int id, input logic [7:0] b[$],
                              input bit app, input bit more,
                              input int stop_after);
        int          w;
        int          nb;
        int          tmo;
        logic [31:0] r;
        logic [31:0] f;
        logic [7:0]  fb[$];
        w  = wid(id);
        nb = b.size() * 8 / w;
        r  = model_reg(b);
        f  = ~r;
        for (int n = 0; n < nb; n++) begin
            if (stop_after >= 0 && n == stop_after) break;
            set_in(id, 1'b1, get_beat(b, n, w), n == nb - 1,
                   app && (n == nb - 1));
            #1;
            tmo = 0;
            while (!ir_s[id] && tmo < 100) begin
                @(posedge clk);
                #2;
                tmo++;
            end
            if (tmo >= 100) chk("in_ready_timeout", 1'b0, 1'b1);
            if (n == nb - 1) begin
                dq.push_back('{id, cyc + 1, f, r == 32'hDEBB_20E3});
                if (app) begin
                    fb = '{f[7:0], f[15:8], f[23:16], f[31:24]};
                    for (int q = 0; q < 32 / w; q++)
                        eq.push_back('{id, get_beat(fb, q, w),
                                       q == 32 / w - 1});
                    em_start[id] = cyc + 1;
                end
            end
            @(posedge clk);
            #1;
        end
        if (!more) set_in(id, 1'b0, 8'h0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int id, input bit toggle, input int abort_k,
                         output int low_ir);
        int tmo;
        bit fin;
        tmo    = 0;
        fin    = 0;
        low_ir = 0;
        seen.delete();
        while (!fin && tmo < 300) begin
            ordy_s[id] = toggle ? ~ordy_s[id] : 1'b1;
            #1;
            if (!ir_s[id]) low_ir++;
            if (abort_k >= 0 && seen.size() == abort_k && ov_s[id]) begin
                ordy_s[id]  = 1'b0;
                start_s[id] = 1'b1;
                @(posedge clk);
                #1;
                start_s[id] = 1'b0;
                purge_em(id);
                fin = 1;
            end else begin
                if (ov_s[id] && ordy_s[id]) begin
                    seen.push_back(get_od(id));
                    if (ol_s[id]) fin = 1;
                end
                @(posedge clk);
                #1;
            end
            tmo++;
        end
        ordy_s[id] = 1'b0;
        if (!fin) chk("drain_timeout", 1'b0, 1'b1);
    endtask

    task automatic rst_checks(input int id);
        chk("rst_fcs_out", fcs_s[id], 32'h0);
        chk("rst_fcs_good", good_s[id], 1'b0);
        chk("rst_crc_done", done_s[id], 1'b0);
        chk("rst_out_valid", ov_s[id], 1'b0);
        chk("rst_out_last", ol_s[id], 1'b0);
        chk("rst_out_data", get_od(id), 8'h0);
        chk("rst_in_ready", ir_s[id], 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s9[$];
        logic [7:0] s13[$];
        logic [7:0] sf[$];
        logic [7:0] e4[4];
        int         lo;
        int         d0;

        s9  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                8'h36, 8'h37, 8'h38, 8'h39};
        s13 = s9;
        s13.push_back(8'h26);
        s13.push_back(8'h39);
        s13.push_back(8'hF4);
        s13.push_back(8'hCB);
        sf  = s9;
        sf[4] = sf[4] ^ 8'h01;
        e4  = '{8'h2, 8'h1, 8'h2, 8'h0};

        for (int i = 0; i < 3; i++) begin
            start_s[i]  = 1'b0;
            ordy_s[i]   = 1'b0;
            em_start[i] = 0;
            done_cnt[i] = 0;
            set_in(i, 1'b0, 8'h0, 1'b0, 1'b0);
        end
        model_reset();

        chk("model_check", ~model_reg(s9), 32'hCBF4_3926);
        chk("model_residue", model_reg(s13), 32'hDEBB_20E3);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        armed = 1;
        for (int i = 0; i < 3; i++) rst_checks(i);

        // width 8: check value, then residue
        send_frame(0, s9, 0, 0, -1);
        idle(1);
        chk("w8_fcs", fcs_s[0], 32'hCBF4_3926);
        send_frame(0, s13, 0, 0, -1);
        idle(1);
        chk("w8_res_fcs", fcs_s[0], 32'h2144_DF1C);
        chk("w8_res_good", good_s[0], 1'b1);

        // width 2: plain and bit-flipped
        send_frame(1, s9, 0, 0, -1);
        idle(1);
        chk("w2_fcs", fcs_s[1], 32'hCBF4_3926);
        chk("w2_good", good_s[1], 1'b0);
        send_frame(1, sf, 0, 0, -1);
        idle(1);
        chk("w2_flip_differs", fcs_s[1] == 32'hCBF4_3926, 1'b0);
        chk("w2_flip_good", good_s[1], 1'b0);

        // width 2 emission, downstream always ready
        send_frame(1, s9, 1, 0, -1);
        drain(1, 0, -1, lo);
        chk("emit_in_ready_low", lo, 16);
        chk("emit_beats", seen.size(), 16);
        for (int i = 0; i < 4; i++)
            chk($sformatf("emit_b%0d", i),
                seen.size() > i ? seen[i] : 8'hFF, e4[i]);
        idle(2);

        // width 2 emission with stalls every other cycle
        send_frame(1, s9, 1, 0, -1);
        drain(1, 1, -1, lo);
        chk("stall_beats", seen.size(), 16);
        idle(2);

        // start aborts emission at beat 5
        send_frame(1, s9, 1, 0, -1);
        drain(1, 0, 5, lo);
        chk("abort_beats", seen.size(), 5);
        idle(3);
        send_frame(1, s9, 0, 0, -1);
        idle(1);
        chk("after_abort_fcs", fcs_s[1], 32'hCBF4_3926);

        // reset in the middle of a frame
        idle(2);
        send_frame(1, s9, 0, 0, 10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) rst_checks(i);
        idle(3);
        send_frame(1, s9, 0, 0, -1);
        idle(1);
        chk("after_rst_fcs", fcs_s[1], 32'hCBF4_3926);

        // width 4: back-to-back frames
        d0 = done_cnt[2];
        send_frame(2, s9, 0, 1, -1);
        chk("b2b_first_fcs", fcs_s[2], 32'hCBF4_3926);
        send_frame(2, s9, 0, 0, -1);
        idle(3);
        chk("b2b_second_fcs", fcs_s[2], 32'hCBF4_3926);
        chk("b2b_done_count", done_cnt[2] - d0, 2);

        idle(2);
        chk("no_pending_done", dq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
